// File: rtl/if_fetch_buf.sv
// ---------------------------------------------------------------------------
// if_fetch_buf
//
// In-order instruction fetch buffer between the PC register and the IF/ID
// register. Each fetch PC gets a bus request with a req/gnt handshake. Up to
// DEPTH fetches are held in a circular buffer, either still waiting on the bus
// or already returned. Returned instructions go to decode in program order.
// A flush or branch redirect empties the buffer. Responses still in flight
// for the discarded fetches are counted in drop_cnt and thrown away on return.
//
// Parameters
//   DEPTH     buffer entries (power of two, 2..8)
//   NOP_INST  value on inst_o when no instruction is valid
//
// Ports
//   clk, rst_n          core clock, asynchronous active-low reset
//   pc_i, ce_i          fetch address and fetch enable from the PC register
//   stalled_i           IF/ID stall; the head is not consumed while high
//   flush_i             pipeline flush
//   ex_branch_flag_i    branch redirect from EX; behaves exactly like flush_i
//   ibus_req_o/addr_o   bus request and word-aligned bus address
//   ibus_gnt_i          bus accepted the request this cycle
//   ibus_rvalid_i/rdata_i  in-order bus response
//   pc_stall_o          fetch not accepted; hold the PC register
//   inst_valid_o        head entry has returned and can be delivered
//   inst_o, inst_addr_o head instruction and its address (NOP_INST / 0 if none)
//
// Optional feature (macro FETCH_MISALIGN_CHK_EN)
//   Adds inst_misalign_o. A misaligned pc_i issues no bus request. It takes an
//   entry at once, already filled with NOP_INST and flagged misaligned.
// ---------------------------------------------------------------------------
module if_fetch_buf #(
    parameter int unsigned DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        stalled_i,
    input  logic        flush_i,
    input  logic        ex_branch_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        pc_stall_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic        inst_misalign_o
`endif
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam int unsigned PW      = AW + 1;
    localparam logic [PW:0] DEPTH_X = (PW+1)'(DEPTH);

    logic [31:0]    addr_q [DEPTH];
    logic [31:0]    data_q [DEPTH];
    logic [DEPTH-1:0] filled_q;
`ifdef FETCH_MISALIGN_CHK_EN
    logic [DEPTH-1:0] misal_q;
`endif

    logic [PW-1:0]  wr_ptr, fill_ptr, rd_ptr, drop_cnt;
    logic [PW-1:0]  occ, span, pend, fill_idx, cand;
    logic [PW:0]    occ_sum;
    logic [AW-1:0]  wr_idx, rd_idx, fill_slot;
    logic           kill, room, mis_pc, alloc, drop_zero;
    logic           rsp_fill, rsp_drop, fill_hit, pop;

    assign kill      = flush_i | ex_branch_flag_i;
    assign occ       = wr_ptr - rd_ptr;
    assign occ_sum   = {1'b0, occ} + {1'b0, drop_cnt};
    // Responses owed to flushed fetches still hold a slot of bus credit.
    assign room      = occ_sum < DEPTH_X;
    assign wr_idx    = wr_ptr[AW-1:0];
    assign rd_idx    = rd_ptr[AW-1:0];
    assign drop_zero = (drop_cnt == '0);

`ifdef FETCH_MISALIGN_CHK_EN
    assign mis_pc = (pc_i[1:0] != 2'b00);
`else
    assign mis_pc = 1'b0;
`endif

    assign ibus_req_o  = ce_i & ~kill & room & ~mis_pc;
    assign ibus_addr_o = {pc_i[31:2], 2'b00};
    assign alloc       = (ibus_req_o & ibus_gnt_i) | (ce_i & ~kill & room & mis_pc);
    assign pc_stall_o  = ce_i & ~alloc & ~kill;

    // The next response goes to the oldest entry that is still unfilled.
    // Entries that were pre-filled at allocation are skipped. pend counts the
    // outstanding entries a kill has to turn into drops.
    always_comb begin
        span     = wr_ptr - fill_ptr;
        fill_idx = fill_ptr;
        fill_hit = 1'b0;
        pend     = '0;
        cand     = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            cand = fill_ptr + PW'(i);
            if ((PW'(i) < span) && !filled_q[cand[AW-1:0]]) begin
                pend = pend + PW'(1);
                if (!fill_hit) begin
                    fill_idx = cand;
                    fill_hit = 1'b1;
                end
            end
        end
    end

    assign fill_slot = fill_idx[AW-1:0];
    assign rsp_drop  = ibus_rvalid_i & ~drop_zero;
    assign rsp_fill  = ibus_rvalid_i & drop_zero & ~kill & fill_hit;

    assign inst_valid_o = (occ != '0) & filled_q[rd_idx];
    assign inst_o       = inst_valid_o ? data_q[rd_idx] : NOP_INST;
    assign inst_addr_o  = inst_valid_o ? addr_q[rd_idx] : 32'h0;
    assign pop          = inst_valid_o & ~stalled_i & ~kill;
`ifdef FETCH_MISALIGN_CHK_EN
    assign inst_misalign_o = inst_valid_o & misal_q[rd_idx];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            fill_ptr <= '0;
            rd_ptr   <= '0;
            drop_cnt <= '0;
            filled_q <= '0;
        end else if (kill) begin
            rd_ptr   <= wr_ptr;
            fill_ptr <= wr_ptr;
            // Every outstanding fetch becomes a drop. A response arriving this
            // cycle pays off one owed response, whether it was already a drop
            // or belonged to a fetch that is being flushed.
            drop_cnt <= drop_cnt + pend - PW'(ibus_rvalid_i);
        end else begin
            wr_ptr <= wr_ptr + PW'(alloc);
            rd_ptr <= rd_ptr + PW'(pop);
            if (rsp_fill) begin
                fill_ptr            <= fill_idx + PW'(1);
                filled_q[fill_slot] <= 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - PW'(1);
            end
            if (alloc) begin
                filled_q[wr_idx] <= mis_pc;
            end
        end
    end

    // The payload needs no reset; the filled bits decide what is visible.
    always_ff @(posedge clk) begin
        if (alloc) begin
            addr_q[wr_idx] <= pc_i;
`ifdef FETCH_MISALIGN_CHK_EN
            misal_q[wr_idx] <= mis_pc;
            if (mis_pc) begin
                data_q[wr_idx] <= NOP_INST;
            end
`endif
        end
        if (rsp_fill) begin
            data_q[fill_slot] <= ibus_rdata_i;
        end
    end

endmodule
